sdram_port_arbiter: RTL and testbench

Parametrised burst scheduler for the multi-port SDRAM controller. It arbitrates NWR write-FIFO ports and NRD read-FIFO ports, keeps a circular address window per port, and issues one burst command at a time (address, length, direction) to the SDRAM command core. Successor to the fixed 2+2 fixed-priority scheme: generic port counts, selectable fixed or round-robin arbitration, read-FIFO headroom check, and per-port zero-length disable.

---
 rtl/sdram_port_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_sdram_port_arbiter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_port_arbiter.sv
// Burst scheduler for the multi-port SDRAM controller.
// Arbitrates write/read FIFO ports and walks a circular address window per port.
module sdram_port_arbiter #(
  parameter int ASIZE      = 22,
  parameter int LSIZE      = 9,
  parameter int NWR        = 2,
  parameter int NRD        = 2,
  parameter int FIFO_DEPTH = 512,
  parameter int ARB_MODE   = 1
) (
  input  logic                 CLK,
  input  logic                 RESET_N,
  input  logic [NWR-1:0]       WR_LOAD,
  input  logic [NWR*ASIZE-1:0] WR_START,
  input  logic [NWR*ASIZE-1:0] WR_MAX,
  input  logic [NWR*LSIZE-1:0] WR_LEN,
  input  logic [NWR*LSIZE-1:0] WR_LEVEL,
  input  logic [NRD-1:0]       RD_LOAD,
  input  logic [NRD*ASIZE-1:0] RD_START,
  input  logic [NRD*ASIZE-1:0] RD_MAX,
  input  logic [NRD*LSIZE-1:0] RD_LEN,
  input  logic [NRD*LSIZE-1:0] RD_LEVEL,
  output logic                 CMD_WR,
  output logic                 CMD_RD,
  output logic [ASIZE-1:0]     CMD_ADDR,
  output logic [LSIZE-1:0]     CMD_LEN,
  input  logic                 CMD_ACK,
  input  logic                 CMD_DONE,
  output logic [NWR-1:0]       WR_SEL,
  output logic [NRD-1:0]       RD_SEL,
  output logic                 BUSY
);

  localparam int N  = NWR + NRD;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_POST  = 2'd3;

  localparam logic [LSIZE+1:0] DEPTH = (LSIZE+2)'(FIFO_DEPTH);

  logic [ASIZE-1:0] start_a [N];
  logic [ASIZE-1:0] max_a   [N];
  logic [LSIZE-1:0] len_in  [N];
  logic [ASIZE-1:0] addr_q  [N];
  logic [LSIZE-1:0] len_q   [N];
  logic [ASIZE:0]   sum_a   [N];
  logic [N-1:0]     load;
  logic [N-1:0]     elig;
  logic [N-1:0]     sel_q;

  logic [1:0]    st_q;
  logic [IW-1:0] ptr_q;
  logic [IW-1:0] gidx_q;
  logic [IW-1:0] win;
  logic [IW-1:0] ptr_nxt;
  logic          found;
  logic          grant;
  logic          sup_q;
  int            idx;

  for (genvar i = 0; i < NWR; i++) begin : g_wr
    assign start_a[i] = WR_START[i*ASIZE +: ASIZE];
    assign max_a[i]   = WR_MAX[i*ASIZE +: ASIZE];
    assign len_in[i]  = WR_LEN[i*LSIZE +: LSIZE];
    assign load[i]    = WR_LOAD[i];
    assign elig[i]    = (len_q[i] != '0) &&
                        (WR_LEVEL[i*LSIZE +: LSIZE] >= len_q[i]);
  end

  for (genvar j = 0; j < NRD; j++) begin : g_rd
    assign start_a[NWR+j] = RD_START[j*ASIZE +: ASIZE];
    assign max_a[NWR+j]   = RD_MAX[j*ASIZE +: ASIZE];
    assign len_in[NWR+j]  = RD_LEN[j*LSIZE +: LSIZE];
    assign load[NWR+j]    = RD_LOAD[j];
    // Headroom: the whole burst must fit in the read FIFO.
    assign elig[NWR+j]    = (len_q[NWR+j] != '0) &&
                            (({2'b00, RD_LEVEL[j*LSIZE +: LSIZE]} +
                              {2'b00, len_q[NWR+j]}) <= DEPTH);
  end

  // Carry bit keeps the wrap compare correct near the top of memory.
  for (genvar i = 0; i < N; i++) begin : g_sum
    assign sum_a[i] = {1'b0, addr_q[i]} + (ASIZE+1)'(len_q[i]);
  end

  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int k = 0; k < N; k++) begin
      idx = (ARB_MODE != 0) ? int'(ptr_q) + k : k;
      if (idx >= N) idx = idx - N;
      if (!found && elig[idx]) begin
        found = 1'b1;
        win   = IW'(idx);
      end
    end
  end

  assign ptr_nxt = (int'(win) == N - 1) ? '0 : win + IW'(1);
  assign grant   = (st_q == S_IDLE) && found && !(|load);

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      st_q     <= S_IDLE;
      CMD_WR   <= 1'b0;
      CMD_RD   <= 1'b0;
      CMD_ADDR <= '0;
      CMD_LEN  <= '0;
      sel_q    <= '0;
      BUSY     <= 1'b0;
      ptr_q    <= '0;
      gidx_q   <= '0;
      sup_q    <= 1'b0;
    end else begin
      case (st_q)
        S_IDLE: begin
          if (grant) begin
            CMD_ADDR <= addr_q[win];
            CMD_LEN  <= len_q[win];
            sel_q    <= N'(1) << win;
            CMD_WR   <= (int'(win) < NWR);
            CMD_RD   <= (int'(win) >= NWR);
            BUSY     <= 1'b1;
            gidx_q   <= win;
            sup_q    <= 1'b0;
            if (ARB_MODE != 0) ptr_q <= ptr_nxt;
            st_q     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (CMD_DONE) begin
            CMD_WR <= 1'b0;
            CMD_RD <= 1'b0;
            st_q   <= S_POST;
          end else if (CMD_ACK) begin
            CMD_WR <= 1'b0;
            CMD_RD <= 1'b0;
            st_q   <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (CMD_DONE) st_q <= S_POST;
        end
        default: begin
          sel_q <= '0;
          BUSY  <= 1'b0;
          st_q  <= S_IDLE;
        end
      endcase
      if (st_q != S_IDLE && load[gidx_q]) sup_q <= 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i < N; i++) begin
        addr_q[i] <= '0;
        len_q[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (load[i]) begin
          addr_q[i] <= start_a[i];
          len_q[i]  <= len_in[i];
        end else if (st_q == S_POST && gidx_q == IW'(i) && !sup_q) begin
          addr_q[i] <= (sum_a[i] < {1'b0, max_a[i]}) ?
                       sum_a[i][ASIZE-1:0] : start_a[i];
        end
      end
    end
  end

  assign WR_SEL = sel_q[NWR-1:0];
  assign RD_SEL = sel_q[N-1:NWR];

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench: round-robin and fixed-priority arbiters driven in lockstep.
// Expected addresses, selects and lengths are hand-computed per step.
module tb_sdram_port_arbiter;

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic [1:0]  WR_LOAD, RD_LOAD;
  logic [43:0] WR_START, WR_MAX, RD_START, RD_MAX;
  logic [17:0] WR_LEN, WR_LEVEL, RD_LEN, RD_LEVEL;
  logic        CMD_ACK, CMD_DONE;

  logic        rr_wr, rr_rd, rr_busy, fx_wr, fx_rd, fx_busy;
  logic [21:0] rr_addr, fx_addr;
  logic [8:0]  rr_len, fx_len;
  logic [1:0]  rr_wsel, rr_rsel, fx_wsel, fx_rsel;

  int ncmp = 0;
  int nerr = 0;

  always #5 CLK = ~CLK;

  sdram_port_arbiter #(.ARB_MODE(1)) u_rr (
    .CLK(CLK), .RESET_N(RESET_N),
    .WR_LOAD(WR_LOAD), .WR_START(WR_START), .WR_MAX(WR_MAX),
    .WR_LEN(WR_LEN), .WR_LEVEL(WR_LEVEL),
    .RD_LOAD(RD_LOAD), .RD_START(RD_START), .RD_MAX(RD_MAX),
    .RD_LEN(RD_LEN), .RD_LEVEL(RD_LEVEL),
    .CMD_WR(rr_wr), .CMD_RD(rr_rd), .CMD_ADDR(rr_addr), .CMD_LEN(rr_len),
    .CMD_ACK(CMD_ACK), .CMD_DONE(CMD_DONE),
    .WR_SEL(rr_wsel), .RD_SEL(rr_rsel), .BUSY(rr_busy)
  );

  sdram_port_arbiter #(.ARB_MODE(0)) u_fx (
    .CLK(CLK), .RESET_N(RESET_N),
    .WR_LOAD(WR_LOAD), .WR_START(WR_START), .WR_MAX(WR_MAX),
    .WR_LEN(WR_LEN), .WR_LEVEL(WR_LEVEL),
    .RD_LOAD(RD_LOAD), .RD_START(RD_START), .RD_MAX(RD_MAX),
    .RD_LEN(RD_LEN), .RD_LEVEL(RD_LEVEL),
    .CMD_WR(fx_wr), .CMD_RD(fx_rd), .CMD_ADDR(fx_addr), .CMD_LEN(fx_len),
    .CMD_ACK(CMD_ACK), .CMD_DONE(CMD_DONE),
    .WR_SEL(fx_wsel), .RD_SEL(fx_rsel), .BUSY(fx_busy)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    WR_LOAD = '0; RD_LOAD = '0; CMD_ACK = 1'b0; CMD_DONE = 1'b0;
    RESET_N = 1'b0;
    #2;
    RESET_N = 1'b1;
    tick();
  endtask

  task automatic set_wr(input int p, input logic [21:0] s,
                        input logic [21:0] m, input logic [8:0] l);
    WR_START[p*22 +: 22] = s;
    WR_MAX[p*22 +: 22]   = m;
    WR_LEN[p*9 +: 9]     = l;
  endtask

  task automatic set_rd(input int p, input logic [21:0] s,
                        input logic [21:0] m, input logic [8:0] l);
    RD_START[p*22 +: 22] = s;
    RD_MAX[p*22 +: 22]   = m;
    RD_LEN[p*9 +: 9]     = l;
  endtask

  task automatic pulse_load(input logic [1:0] w, input logic [1:0] r);
    WR_LOAD = w; RD_LOAD = r;
    tick();
    WR_LOAD = '0; RD_LOAD = '0;
  endtask

  task automatic grant_chk(input string tag, input logic [21:0] ra,
                           input logic [3:0] rs, input logic [21:0] fa,
                           input logic [3:0] fs, input logic [8:0] l);
    int n = 0;
    while (!(rr_wr || rr_rd) && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_timeout"}, 32'(n < 20), 1);
    chk({tag, "_addr"}, 32'(rr_addr), 32'(ra));
    chk({tag, "_sel"}, 32'({rr_rsel, rr_wsel}), 32'(rs));
    chk({tag, "_len"}, 32'(rr_len), 32'(l));
    chk({tag, "_dir"}, 32'({rr_rd, rr_wr}), 32'({|rs[3:2], |rs[1:0]}));
    chk({tag, "_fxaddr"}, 32'(fx_addr), 32'(fa));
    chk({tag, "_fxsel"}, 32'({fx_rsel, fx_wsel}), 32'(fs));
  endtask

  task automatic ack_step(input string tag);
    tick();
    chk({tag, "_held"}, 32'(rr_wr | rr_rd), 1);
    CMD_ACK = 1'b1;
    tick();
    CMD_ACK = 1'b0;
    chk({tag, "_drop"}, 32'({rr_wr, rr_rd, rr_busy}), 32'(3'b001));
  endtask

  task automatic done_step(input string tag);
    tick();
    CMD_DONE = 1'b1;
    tick();
    CMD_DONE = 1'b0;
    tick();
    chk({tag, "_idle"}, 32'({rr_rsel, rr_wsel, rr_busy}), 0);
  endtask

  initial begin
    WR_START = '0; WR_MAX = '0; WR_LEN = '0; WR_LEVEL = '0;
    RD_START = '0; RD_MAX = '0; RD_LEN = '0; RD_LEVEL = '0;
    do_reset();

    // reset state, levels high but every port disabled
    WR_LEVEL = {9'd511, 9'd511};
    chk("rst_out", 32'({rr_wr, rr_rd, rr_wsel, rr_rsel, rr_busy}), 0);
    chk("rst_addr", 32'({rr_addr, rr_len}), 0);
    repeat (5) tick();
    chk("rst_nogrant", 32'(rr_busy | fx_busy), 0);

    // single write port, window 0..1024 step 256, wraps on the fifth
    WR_LEVEL = {9'd0, 9'd256};
    set_wr(0, 22'h0, 22'd1024, 9'd256);
    pulse_load(2'b01, 2'b00);
    for (int k = 0; k < 5; k++) begin
      grant_chk("single", 22'((k % 4) * 256), 4'b0001,
                22'((k % 4) * 256), 4'b0001, 9'd256);
      ack_step("single");
      done_step("single");
    end

    // two permanently eligible write ports: rr alternates, fixed stays on 0
    do_reset();
    WR_LEVEL = {9'd256, 9'd256};
    set_wr(0, 22'h1000, 22'h2000, 9'd16);
    set_wr(1, 22'h2000, 22'h3000, 9'd16);
    pulse_load(2'b11, 2'b00);
    grant_chk("arb0", 22'h1000, 4'b0001, 22'h1000, 4'b0001, 9'd16);
    ack_step("arb0"); done_step("arb0");
    grant_chk("arb1", 22'h2000, 4'b0010, 22'h1010, 4'b0001, 9'd16);
    ack_step("arb1"); done_step("arb1");
    grant_chk("arb2", 22'h1010, 4'b0001, 22'h1020, 4'b0001, 9'd16);
    ack_step("arb2"); done_step("arb2");
    grant_chk("arb3", 22'h2010, 4'b0010, 22'h1030, 4'b0001, 9'd16);
    ack_step("arb3"); done_step("arb3");

    // read headroom with depth 512 and length 256
    do_reset();
    WR_LEVEL = '0;
    set_wr(0, 22'h0, 22'h0, 9'd0);
    set_wr(1, 22'h0, 22'h0, 9'd0);
    set_rd(0, 22'h500, 22'h10000, 9'd256);
    set_rd(1, 22'h900, 22'h10000, 9'd0);
    RD_LEVEL = {9'd0, 9'd257};
    pulse_load(2'b00, 2'b11);
    repeat (6) tick();
    chk("rd_257", 32'(rr_busy | fx_busy), 0);
    RD_LEVEL = {9'd0, 9'd256};
    grant_chk("rd_256", 22'h500, 4'b0100, 22'h500, 4'b0100, 9'd256);
    ack_step("rd_256");
    RD_LEVEL = {9'd0, 9'd257};
    done_step("rd_256");
    repeat (6) tick();
    chk("rd_257b", 32'(rr_busy | fx_busy), 0);
    RD_LEVEL = {9'd0, 9'd511};
    repeat (6) tick();
    chk("rd_len0", 32'(rr_busy | fx_busy), 0);

    // load during WAIT wins over the post-burst advance
    do_reset();
    RD_LEVEL = '0;
    set_rd(0, 22'h0, 22'h0, 9'd0);
    WR_LEVEL = {9'd0, 9'd256};
    set_wr(0, 22'h0, 22'h200000, 9'd256);
    pulse_load(2'b01, 2'b00);
    grant_chk("ld0", 22'h0, 4'b0001, 22'h0, 4'b0001, 9'd256);
    ack_step("ld0");
    set_wr(0, 22'h100000, 22'h200000, 9'd128);
    pulse_load(2'b01, 2'b00);
    chk("ld_stable", 32'({rr_addr, rr_len}), 32'({22'h0, 9'd256}));
    done_step("ld0");
    grant_chk("ld1", 22'h100000, 4'b0001, 22'h100000, 4'b0001, 9'd128);
    ack_step("ld1"); done_step("ld1");
    grant_chk("ld2", 22'h100080, 4'b0001, 22'h100080, 4'b0001, 9'd128);
    ack_step("ld2");

    // asynchronous reset while waiting for DONE
    RESET_N = 1'b0;
    #1;
    chk("arst_rr", 32'({rr_wr, rr_rd, rr_wsel, rr_rsel, rr_busy}), 0);
    chk("arst_fx", 32'({fx_wr, fx_rd, fx_wsel, fx_rsel, fx_busy}), 0);
    chk("arst_cmd", 32'({rr_addr, rr_len}), 0);
    tick();
    RESET_N = 1'b1;
    repeat (6) tick();
    chk("arst_nogrant", 32'(rr_busy | fx_busy), 0);

    // ACK and DONE together in ISSUE, window at the top of memory
    set_wr(0, 22'h3FFE00, 22'h3FFFFF, 9'd256);
    pulse_load(2'b01, 2'b00);
    grant_chk("top0", 22'h3FFE00, 4'b0001, 22'h3FFE00, 4'b0001, 9'd256);
    CMD_ACK = 1'b1; CMD_DONE = 1'b1;
    tick();
    CMD_ACK = 1'b0; CMD_DONE = 1'b0;
    chk("top0_post", 32'({rr_wr, rr_rd, rr_wsel, rr_busy}), 32'(5'b00011));
    tick();
    chk("top0_idle", 32'({rr_wsel, rr_busy}), 0);
    grant_chk("top1", 22'h3FFF00, 4'b0001, 22'h3FFF00, 4'b0001, 9'd256);
    ack_step("top1"); done_step("top1");
    grant_chk("top2", 22'h3FFE00, 4'b0001, 22'h3FFE00, 4'b0001, 9'd256);
    ack_step("top2"); done_step("top2");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
